// File: rtl/usb_gpio_word_bridge.sv
// Host-side GPIO word link peer: 32-bit words <-> MSB-first bytes with flicker handshakes.
// Optional BRIDGE_SYNC_EN: 2-flop synchroniser on gpio_from_pulpino for foreign-clock peers.
module usb_gpio_word_bridge #(
    parameter int RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               tx_word,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [31:0]               rx_word,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [11:0]               gpio_to_pulpino,
    input  logic [11:0]               gpio_from_pulpino
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

    logic [11:0] from;

`ifdef BRIDGE_SYNC_EN
    logic [11:0] sync0;
    logic [11:0] sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= gpio_from_pulpino;
            sync1 <= sync0;
        end
    end

    assign from = sync1;
`else
    assign from = gpio_from_pulpino;
`endif

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_B_REQ,
        TX_B_REL,
        TX_W_REQ,
        TX_W_REL
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_B_ACK,
        RX_W_WAIT,
        RX_W_ACK
    } rx_state_t;

    tx_state_t   tx_state;
    logic [31:0] tx_buf;
    logic [1:0]  tx_cnt;
    logic [7:0]  tx_data;
    logic        byte_wr;
    logic        word_wr;

    rx_state_t   rx_state;
    logic [31:0] rx_shift;
    logic [2:0]  rx_cnt;
    logic        byte_ack;
    logic        word_ack;

    logic [31:0] mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;

    assign gpio_to_pulpino = {word_wr, word_ack, byte_wr, byte_ack, tx_data};

    // tx_buf shifts left per byte so the byte on the wire is always tx_buf[31:24]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
            tx_buf   <= '0;
            tx_cnt   <= '0;
            tx_data  <= '0;
            byte_wr  <= 1'b0;
            word_wr  <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_buf   <= tx_word;
                        tx_cnt   <= '0;
                        tx_data  <= tx_word[31:24];
                        byte_wr  <= 1'b1;
                        tx_ready <= 1'b0;
                        tx_state <= TX_B_REQ;
                    end
                end
                TX_B_REQ: begin
                    if (from[8]) begin
                        byte_wr  <= 1'b0;
                        tx_state <= TX_B_REL;
                    end
                end
                TX_B_REL: begin
                    if (!from[8]) begin
                        if (tx_cnt == 2'd3) begin
                            word_wr  <= 1'b1;
                            tx_state <= TX_W_REQ;
                        end else begin
                            tx_cnt   <= tx_cnt + 2'd1;
                            tx_buf   <= {tx_buf[23:0], 8'h00};
                            tx_data  <= tx_buf[23:16];
                            byte_wr  <= 1'b1;
                            tx_state <= TX_B_REQ;
                        end
                    end
                end
                TX_W_REQ: begin
                    if (from[10]) begin
                        word_wr  <= 1'b0;
                        tx_state <= TX_W_REL;
                    end
                end
                TX_W_REL: begin
                    if (!from[10]) begin
                        tx_data  <= '0;
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign full     = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign rx_count = count;
    assign rx_word  = rx_valid ? mem[rd_ptr] : '0;
    assign pop      = rx_valid && rx_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still take the word
    assign push     = (rx_state == RX_W_WAIT) && from[11] && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_cnt   <= '0;
            byte_ack <= 1'b0;
            word_ack <= 1'b0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (from[9]) begin
                        rx_shift <= {rx_shift[23:0], from[7:0]};
                        rx_cnt   <= rx_cnt + 3'd1;
                        byte_ack <= 1'b1;
                        rx_state <= RX_B_ACK;
                    end
                end
                RX_B_ACK: begin
                    if (!from[9]) begin
                        byte_ack <= 1'b0;
                        rx_state <= (rx_cnt == 3'd4) ? RX_W_WAIT : RX_IDLE;
                    end
                end
                RX_W_WAIT: begin
                    if (push) begin
                        word_ack <= 1'b1;
                        rx_state <= RX_W_ACK;
                    end
                end
                RX_W_ACK: begin
                    if (!from[11]) begin
                        word_ack <= 1'b0;
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule
